// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes, FSM state codes, default width and small op decoders.
package mdu_seq_ctrl_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } md_state_e;

  // Divide ops have the upper op bit set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops have the lower op bit clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Single WIDTH+1 bit adder/subtractor shared by the multiply accumulate and
// the divide trial subtraction. Subtraction inverts b and injects carry-in.
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);

  logic [WIDTH:0]   b_eff;
  logic [WIDTH+1:0] full;

  // Operand conditioning and the add itself, with the carry kept one bit up.
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH + 2)'(sub_i);
  end

  assign sum_o  = full[WIDTH:0];
  assign cout_o = full[WIDTH+1];

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Signed ops are run
// on magnitudes (shift-add multiply, restoring divide) and re-signed at FIX.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_md_start,
  input  logic [1:0]       ex_md_op,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic             ex_mthi,
  input  logic             ex_mtlo,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;  // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / quotient bits
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Shared adder and its operand selection.
  logic [WIDTH:0] add_a, add_b, add_sum, hi_step;
  logic           add_cout;

  assign add_a = op_is_div(op_q) ? {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]} : acc_hi_q;
  assign add_b = {1'b0, opnd_q};

  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (op_is_div(op_q)),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Operand magnitudes for PREP and the FIX-stage negations (separate incrementers).
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b, quo_neg, rem_neg;
  logic [2*WIDTH-1:0] prod, prod_neg, prod_fix;

  assign sign_a   = op_is_signed(op_q) & a_q[WIDTH-1];
  assign sign_b   = op_is_signed(op_q) & b_q[WIDTH-1];
  assign mag_a    = sign_a ? (~a_q + WIDTH'(1)) : a_q;
  assign mag_b    = sign_b ? (~b_q + WIDTH'(1)) : b_q;
  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_neg = ~prod + (2*WIDTH)'(1);
  assign prod_fix = neg_quo_q ? prod_neg : prod;
  assign quo_neg  = ~acc_lo_q + WIDTH'(1);
  assign rem_neg  = ~acc_hi_q[WIDTH-1:0] + WIDTH'(1);
  assign hi_step  = acc_lo_q[0] ? add_sum : acc_hi_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath sequencing; cancel beats MTHI/MTLO beats start.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    if (md_cancel) begin
      state_d = S_IDLE;
    end else if (ex_mthi || ex_mtlo) begin
      state_d = S_IDLE;
      if (ex_mthi) hi_d = ex_a;
      if (ex_mtlo) lo_d = ex_a;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ex_md_start) begin
            a_d     = ex_a;
            b_d     = ex_b;
            op_d    = ex_md_op;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          acc_hi_d  = '0;
          opnd_d    = op_is_div(op_q) ? mag_b : mag_a;
          acc_lo_d  = op_is_div(op_q) ? mag_a : mag_b;
          cnt_d     = CW'(WIDTH - 1);
          state_d   = S_RUN;
        end
        S_RUN: begin
          if (op_is_div(op_q)) begin
            acc_hi_d = add_cout ? add_sum : add_a;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], add_cout};
          end else begin
            acc_hi_d = {1'b0, hi_step[WIDTH:1]};
            acc_lo_d = {hi_step[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          if (op_is_div(op_q)) begin
            lo_d = (opnd_q == '0) ? '1 : (neg_quo_q ? quo_neg : acc_lo_q);
            hi_d = neg_rem_q ? rem_neg : acc_hi_q[WIDTH-1:0];
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign md_busy = (state_q != S_IDLE);
  assign md_done = done_q;
  assign md_hi   = hi_q;
  assign md_lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed and randomized bench for mdu_seq_ctrl against a 64-bit arithmetic model.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_md_start;
  logic [1:0]  ex_md_op;
  logic [31:0] ex_a, ex_b;
  logic        ex_mthi, ex_mtlo, md_cancel;
  logic        md_busy, md_done;
  logic [31:0] md_hi, md_lo;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_hi, exp_lo;

  mdu_seq_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_md_start (ex_md_start),
    .ex_md_op    (ex_md_op),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_mthi     (ex_mthi),
    .ex_mtlo     (ex_mtlo),
    .md_cancel   (md_cancel),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_hi       (md_hi),
    .md_lo       (md_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: {HI, LO} from plain arithmetic on the architectural rules.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    logic busy1, busy33;
    ex_md_start = 1'b1;
    ex_md_op    = op;
    ex_a        = a;
    ex_b        = b;
    tick();
    ex_md_start = 1'b0;
    ex_a        = $urandom;
    ex_b        = $urandom;
    ex_md_op    = 2'($urandom);
    cyc = 0;
    busy1 = 1'b0;
    busy33 = 1'b0;
    while (md_done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 1) busy1 = md_busy;
      if (cyc == 33) busy33 = md_busy;
    end
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    check({tag, " latency"}, 64'(cyc), 64'(34));
    check({tag, " busy_first"}, 64'(busy1), 64'(1));
    check({tag, " busy_last"}, 64'(busy33), 64'(1));
    check({tag, " busy_at_done"}, 64'(md_busy), 64'(0));
    check({tag, " hi"}, 64'(md_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(md_lo), 64'(exp_lo));
    $display("op %s op=%0d a=%h b=%h -> hi=%h lo=%h cyc=%0d", tag, op, a, b, md_hi, md_lo, cyc);
    tick();
    check({tag, " done_pulse"}, 64'(md_done), 64'(0));
  endtask

  // Watches a window of cycles and checks that no done pulse appears.
  task automatic no_done_window(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= md_done;
    end
    check({tag, " no_done"}, 64'(seen), 64'(0));
  endtask

  task automatic start_and_wait(input logic [1:0] op, input int cycles);
    ex_md_start = 1'b1;
    ex_md_op    = op;
    ex_a        = $urandom;
    ex_b        = $urandom;
    tick();
    ex_md_start = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; ex_md_start = 0; ex_md_op = 0; ex_a = 0; ex_b = 0;
    ex_mthi = 0; ex_mtlo = 0; md_cancel = 0;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", 64'(md_busy), 64'(0));
    check("reset done", 64'(md_done), 64'(0));
    check("reset hi", 64'(md_hi), 64'(0));
    check("reset lo", 64'(md_lo), 64'(0));
    exp_hi = 0; exp_lo = 0;

    // Directed vectors with literal results.
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB);
    run_op("mult_min2", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("div_m5d0", 2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF);

    // Randomized ops against the model.
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 9));
        1: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, ref_md(op, a, b));
    end

    // Cancel during RUN cycle 10.
    start_and_wait(2'b01, 10);
    md_cancel = 1'b1;
    tick();
    md_cancel = 1'b0;
    check("cancel busy", 64'(md_busy), 64'(0));
    check("cancel hi", 64'(md_hi), 64'(exp_hi));
    check("cancel lo", 64'(md_lo), 64'(exp_lo));
    no_done_window("cancel");
    $display("txn cancel_run hi=%h lo=%h busy=%0d", md_hi, md_lo, md_busy);

    // MTHI while busy aborts the op and writes HI only.
    start_and_wait(2'b10, 5);
    ex_mthi = 1'b1;
    ex_a    = 32'h12345678;
    tick();
    ex_mthi = 1'b0;
    exp_hi  = 32'h12345678;
    check("mthi_busy busy", 64'(md_busy), 64'(0));
    check("mthi_busy hi", 64'(md_hi), 64'(exp_hi));
    check("mthi_busy lo", 64'(md_lo), 64'(exp_lo));
    no_done_window("mthi_busy");
    $display("txn mthi_busy hi=%h lo=%h", md_hi, md_lo);

    // MTLO together with start in IDLE: write wins, no op launched.
    ex_mtlo = 1'b1; ex_md_start = 1'b1; ex_a = 32'hCAFEF00D; ex_b = 32'd3;
    tick();
    ex_mtlo = 1'b0; ex_md_start = 1'b0;
    exp_lo = 32'hCAFEF00D;
    check("mtlo_start busy", 64'(md_busy), 64'(0));
    check("mtlo_start lo", 64'(md_lo), 64'(exp_lo));
    check("mtlo_start hi", 64'(md_hi), 64'(exp_hi));
    tick();
    check("mtlo_start busy2", 64'(md_busy), 64'(0));
    $display("txn mtlo_start hi=%h lo=%h", md_hi, md_lo);

    // MTHI and MTLO together write both.
    ex_mthi = 1'b1; ex_mtlo = 1'b1; ex_a = 32'h0BADBEEF;
    tick();
    ex_mthi = 1'b0; ex_mtlo = 1'b0;
    exp_hi = 32'h0BADBEEF; exp_lo = 32'h0BADBEEF;
    check("mthilo hi", 64'(md_hi), 64'(exp_hi));
    check("mthilo lo", 64'(md_lo), 64'(exp_lo));
    $display("txn mthi_mtlo hi=%h lo=%h", md_hi, md_lo);

    // Cancel beats MTHI; cancel in IDLE drops a start.
    md_cancel = 1'b1; ex_mthi = 1'b1; ex_md_start = 1'b1; ex_a = 32'h55555555;
    tick();
    md_cancel = 1'b0; ex_mthi = 1'b0; ex_md_start = 1'b0;
    check("cancel_idle busy", 64'(md_busy), 64'(0));
    check("cancel_idle hi", 64'(md_hi), 64'(exp_hi));
    $display("txn cancel_idle hi=%h lo=%h busy=%0d", md_hi, md_lo, md_busy);

    // Operation still works after the aborts.
    run_op("post_abort", 2'b00, 32'd12, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFE8);

    // Reset mid-op clears everything.
    start_and_wait(2'b00, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run busy", 64'(md_busy), 64'(0));
    check("rst_run done", 64'(md_done), 64'(0));
    check("rst_run hi", 64'(md_hi), 64'(0));
    check("rst_run lo", 64'(md_lo), 64'(0));
    $display("txn rst_run hi=%h lo=%h busy=%0d", md_hi, md_lo, md_busy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
